// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: next-PC selector encodings,
// the NOP word, the IF/ID register layout and the branch-offset helper.
package fetch_stage_pkg;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

   // Sign-extended word offset of a branch immediate, as a byte offset.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection: PC+4, branch target, jump target or
// register target. Redirects are only honoured for a real instruction in D.
module npc_calc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic [25:0] index_d,
   input  logic        valid_d,
   input  logic [1:0]  npc_sel,
   input  logic        cmp_true,
   input  logic [31:0] rs_d,
   output logic [31:0] next_pc
);

   logic [31:0] pc4_f;
   logic [31:0] pc4_d;
   logic [31:0] br_target;
   logic [31:0] j_target;

   assign pc4_f     = pc_f + 32'd4;
   assign pc4_d     = pc_d + 32'd4;
   assign br_target = pc4_d + branch_offset(index_d[15:0]);
   assign j_target  = {pc4_d[31:28], index_d, 2'b00};

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred for next_pc.
      next_pc = pc4_f;
      if (valid_d) begin
         case (npc_sel)
            NPC_BR:  if (cmp_true) next_pc = br_target;
            NPC_J:   next_pc = j_target;
            NPC_JR:  next_pc = rs_d;
            default: next_pc = pc4_f;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with stall
// and bubble control, and link/immediate taps for the decode stage.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        clr_d,
   input  logic [1:0]  npc_sel,
   input  logic        cmp_true,
   input  logic [31:0] rs_d,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [15:0] imm16_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d
);

   // The memory wraps by dropping high address bits, so its depth must be a
   // power of two.
   if ((IMEM_WORDS < 1) || ((IMEM_WORDS & (IMEM_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("fetch_stage: IMEM_WORDS must be a power of two");
   end

   logic [31:0] pc_f;
   logic [31:0] next_pc;
   ifid_t       ifid;

   npc_calc u_npc_calc (
      .pc_f     (pc_f),
      .pc_d     (ifid.pc),
      .index_d  (ifid.instr[25:0]),
      .valid_d  (ifid.valid),
      .npc_sel  (npc_sel),
      .cmp_true (cmp_true),
      .rs_d     (rs_d),
      .next_pc  (next_pc)
   );

   // Stall wins over clr_d; a bubble still lets the PC advance so the
   // instruction currently in F is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f <= RESET_PC;
         ifid <= '{instr: NOP, pc: RESET_PC, valid: 1'b0};
      end else if (!stall) begin
         // NOTE: non-blocking assignments let the IF/ID load see the old
         // pc_f in the same edge that pc_f takes next_pc.
         pc_f <= next_pc;
         if (clr_d) begin
            ifid <= '{instr: NOP, pc: pc_f, valid: 1'b0};
         end else begin
            ifid <= '{instr: imem_rdata, pc: pc_f, valid: 1'b1};
         end
      end
   end

   assign imem_addr = pc_f;
   assign instr_d   = ifid.instr;
   assign pc_d      = ifid.pc;
   assign valid_d   = ifid.valid;
   assign imm16_d   = ifid.instr[15:0];
   assign pc8_d     = ifid.pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues hand-computed expected
// outputs per edge; the monitor pops and compares after each edge or reset.
module tb_fetch_stage;

   localparam int IMEM_WORDS = 1024;
   localparam int AW         = $clog2(IMEM_WORDS);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic [15:0] imm;
      logic        valid;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        clr_d = 1'b0;
   logic [1:0]  npc_sel = 2'b00;
   logic        cmp_true = 1'b0;
   logic [31:0] rs_d = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [15:0] imm16_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;

   logic [31:0] mem [IMEM_WORDS];
   exp_t        sb [$];
   string       sb_name [$];
   int          n_vec = 0;
   int          n_bad = 0;

   fetch_stage #(.RESET_PC(32'h0000_3000), .IMEM_WORDS(IMEM_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .clr_d      (clr_d),
      .npc_sel    (npc_sel),
      .cmp_true   (cmp_true),
      .rs_d       (rs_d),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .instr_d    (instr_d),
      .imm16_d    (imm16_d),
      .pc_d       (pc_d),
      .pc8_d      (pc8_d),
      .valid_d    (valid_d)
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[AW+1:2]];

   function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] pc8,
                               input logic [15:0] imm, input logic valid);
      return '{addr: addr, instr: instr, pc: pc, pc8: pc8, imm: imm, valid: valid};
   endfunction

   // Apply inputs at the falling edge and queue the state expected after the
   // following rising edge.
   task automatic cyc(input string name, input logic rn, input logic st, input logic cl,
                      input logic [1:0] sel, input logic cmp, input logic [31:0] rs,
                      input exp_t e);
      @(negedge clk);
      rst_n    = rn;
      stall    = st;
      clr_d    = cl;
      npc_sel  = sel;
      cmp_true = cmp;
      rs_d     = rs;
      sb.push_back(e);
      sb_name.push_back(name);
   endtask

   task automatic async_reset(input string name, input exp_t e);
      @(negedge clk);
      npc_sel = 2'b10;
      #2;
      sb.push_back(e);
      sb_name.push_back(name);
      rst_n = 1'b0;
   endtask

   // Monitor
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (sb.size() != 0) begin
            e  = sb.pop_front();
            nm = sb_name.pop_front();
            n_vec++;
            if ({imem_addr, instr_d, pc_d, pc8_d, imm16_d, valid_d} !== e) begin
               n_bad++;
               $display("FAIL %s: got addr=%h instr=%h pc=%h pc8=%h imm=%h v=%b, want addr=%h instr=%h pc=%h pc8=%h imm=%h v=%b",
                        nm, imem_addr, instr_d, pc_d, pc8_d, imm16_d, valid_d,
                        e.addr, e.instr, e.pc, e.pc8, e.imm, e.valid);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Driver
   initial begin
      exp_t rst_e;
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'hA000_0000 | i;
      mem[0] = 32'h0800_0C10;  // j 0x0000C10
      mem[1] = 32'h2009_0006;
      mem[2] = 32'h1000_FFFF;  // beq $0,$0,-1
      mem[3] = 32'h200A_0007;
      mem[4] = 32'h200B_0008;

      rst_e = mk(32'h3000, 32'h0, 32'h3000, 32'h3008, 16'h0000, 1'b0);

      cyc("reset",      1'b0, 0, 0, 2'b00, 0, 32'h0,    rst_e);
      cyc("free_run1",  1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h3004, 32'h0800_0C10, 32'h3000, 32'h3008, 16'h0C10, 1'b1));
      cyc("free_run2",  1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h3008, 32'h2009_0006, 32'h3004, 32'h300C, 16'h0006, 1'b1));
      cyc("free_run3",  1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h300C, 32'h1000_FFFF, 32'h3008, 32'h3010, 16'hFFFF, 1'b1));
      cyc("br_taken",   1'b1, 0, 0, 2'b01, 1, 32'h0,
          mk(32'h3008, 32'h200A_0007, 32'h300C, 32'h3014, 16'h0007, 1'b1));
      cyc("after_br",   1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h300C, 32'h1000_FFFF, 32'h3008, 32'h3010, 16'hFFFF, 1'b1));
      cyc("br_not",     1'b1, 0, 0, 2'b01, 0, 32'h0,
          mk(32'h3010, 32'h200A_0007, 32'h300C, 32'h3014, 16'h0007, 1'b1));
      cyc("jr",         1'b1, 0, 0, 2'b11, 0, 32'h3400,
          mk(32'h3400, 32'h200B_0008, 32'h3010, 32'h3018, 16'h0008, 1'b1));
      cyc("after_jr",   1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h3404, 32'hA000_0100, 32'h3400, 32'h3408, 16'h0100, 1'b1));
      cyc("stall_clr1", 1'b1, 1, 1, 2'b11, 0, 32'h5000,
          mk(32'h3404, 32'hA000_0100, 32'h3400, 32'h3408, 16'h0100, 1'b1));
      cyc("stall_clr2", 1'b1, 1, 1, 2'b00, 0, 32'h0,
          mk(32'h3404, 32'hA000_0100, 32'h3400, 32'h3408, 16'h0100, 1'b1));
      cyc("clr_only",   1'b1, 0, 1, 2'b00, 0, 32'h0,
          mk(32'h3408, 32'h0, 32'h3404, 32'h340C, 16'h0000, 1'b0));
      cyc("bubble_j",   1'b1, 0, 0, 2'b10, 0, 32'h0,
          mk(32'h340C, 32'hA000_0102, 32'h3408, 32'h3410, 16'h0102, 1'b1));
      async_reset("async_rst", rst_e);
      cyc("rst_hold",   1'b0, 0, 0, 2'b10, 0, 32'h0,    rst_e);
      cyc("rst_resume", 1'b1, 0, 0, 2'b10, 0, 32'h0,
          mk(32'h3004, 32'h0800_0C10, 32'h3000, 32'h3008, 16'h0C10, 1'b1));
      cyc("jump",       1'b1, 0, 0, 2'b10, 0, 32'h0,
          mk(32'h3040, 32'h2009_0006, 32'h3004, 32'h300C, 16'h0006, 1'b1));
      cyc("after_j",    1'b1, 0, 0, 2'b00, 0, 32'h0,
          mk(32'h3044, 32'hA000_0010, 32'h3040, 32'h3048, 16'h0010, 1'b1));
      cyc("stall_only", 1'b1, 1, 0, 2'b11, 0, 32'h0,
          mk(32'h3044, 32'hA000_0010, 32'h3040, 32'h3048, 16'h0010, 1'b1));
      cyc("br_fwd",     1'b1, 0, 0, 2'b01, 1, 32'h0,
          mk(32'h3084, 32'hA000_0011, 32'h3044, 32'h304C, 16'h0011, 1'b1));

      for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expected responses never compared, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
